// File: rtl/exec_monitor.sv
// exec_monitor: watches PC progress, core exceptions and memory-port address ranges; captures the
// first violation, drains for HOLDOFF cycles, then raises sticky halt. Optional MON_CLEAR_EN adds clear.
module exec_monitor #(
   parameter int PC_WIDTH   = 32,
   parameter int TIMEOUT    = 100,
   parameter int CNT_WIDTH  = 8,
   parameter int NPORTS     = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int RANGE_BITS = 17,
   parameter int HOLDOFF    = 1,
   localparam int PORT_W    = NPORTS > 1 ? $clog2(NPORTS) : 1,
   localparam int HW        = $clog2(HOLDOFF + 2)
) (
   input  logic                         clk,
   input  logic                         resetb,
   input  logic [PC_WIDTH-1:0]          pc,
   input  logic                         exception,
   input  logic [NPORTS-1:0]            port_ready,
   input  logic [NPORTS*ADDR_WIDTH-1:0] port_addr,
`ifdef MON_CLEAR_EN
   input  logic                         clear,
`endif
   output logic                         halt,
   output logic [1:0]                   halt_cause,
   output logic [PORT_W-1:0]            halt_port,
   output logic [ADDR_WIDTH-1:0]        halt_addr,
   output logic [CNT_WIDTH-1:0]         stall_count
);
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
   state_t state;
   logic [PC_WIDTH-1:0] prev_pc;
   logic [HW-1:0] hold;
   logic [ADDR_WIDTH-1:0] pc_ext;
   logic range_hit;
   logic [PORT_W-1:0] range_port;
   logic [ADDR_WIDTH-1:0] range_addr;
   logic [1:0] viol_cause;
   logic [PORT_W-1:0] viol_port;
   logic [ADDR_WIDTH-1:0] viol_addr;

   if (PC_WIDTH >= ADDR_WIDTH) begin : g_trunc
      assign pc_ext = pc[ADDR_WIDTH-1:0];
   end else begin : g_ext
      assign pc_ext = {{(ADDR_WIDTH-PC_WIDTH){1'b0}}, pc};
   end

   // Scan downward so the lowest offending port is the one left standing.
   always_comb begin
      range_hit = 1'b0;
      range_port = '0;
      range_addr = '0;
      for (int i = NPORTS - 1; i >= 0; i--)
         if (port_ready[i] && |port_addr[i*ADDR_WIDTH+RANGE_BITS +: ADDR_WIDTH-RANGE_BITS]) begin
            range_hit = 1'b1;
            range_port = PORT_W'(i);
            range_addr = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
   end

   always_comb begin
      viol_cause = exception ? 2'd2 : range_hit ? 2'd3 : (stall_count > CNT_WIDTH'(TIMEOUT)) ? 2'd1 : 2'd0;
      viol_port = (!exception && range_hit) ? range_port : '0;
      viol_addr = (!exception && range_hit) ? range_addr : pc_ext;
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state <= RUN;
         prev_pc <= '0;
         stall_count <= '0;
         hold <= '0;
         halt <= 1'b0;
         halt_cause <= '0;
         halt_port <= '0;
         halt_addr <= '0;
      end else begin
         case (state)
            RUN: begin
               prev_pc <= pc;
               stall_count <= (pc != prev_pc) ? '0 : (&stall_count) ? stall_count : stall_count + 1'b1;
               if (viol_cause != 2'd0) begin
                  halt_cause <= viol_cause;
                  halt_port <= viol_port;
                  halt_addr <= viol_addr;
                  hold <= HW'(HOLDOFF);
                  state <= (HOLDOFF == 0) ? HALTED : DRAIN;
                  halt <= (HOLDOFF == 0);
               end
            end
            DRAIN: begin
               hold <= hold - 1'b1;
               if (hold == HW'(1)) begin
                  state <= HALTED;
                  halt <= 1'b1;
               end
            end
            HALTED: begin
`ifdef MON_CLEAR_EN
               if (clear) begin
                  state <= RUN;
                  halt <= 1'b0;
                  prev_pc <= pc;
                  stall_count <= '0;
                  halt_cause <= '0;
                  halt_port <= '0;
                  halt_addr <= '0;
               end
`endif
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule
